// File: rtl/pipe_field_gen.sv
`default_nettype none
// ============================================================================
// Module   : pipe_field_gen
// Purpose  : Scrolling pipe-obstacle field for the bird game; optional spawn
//            interval jitter enabled by defining PIPE_SPAWN_JITTER_EN.
// Revision : 1.0  initial release
// ============================================================================
module pipe_field_gen #(
  parameter int COLS           = 16,
  parameter int ROWS           = 16,
  parameter int GAP            = 4,
  parameter int SPAWN_INTERVAL = 6,
  parameter int BIRD_COL       = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     halt,
  input  logic                     tick,
  input  logic [5:0]               rnd,
  output logic [COLS*ROWS-1:0]     pipe_map,
  output logic                     pipe_at_bird,
  output logic [$clog2(ROWS)-1:0]  gap_top_at_bird,
  output logic [7:0]               score,
  output logic                     spawn,
  output logic                     running
);

  localparam int RW      = $clog2(ROWS);
  localparam int MAX_TOP = ROWS - GAP;
  // Wide enough for the largest jittered limit, SPAWN_INTERVAL+2.
  localparam int CW      = $clog2(SPAWN_INTERVAL + 3);

  localparam logic [RW:0]   MAX_TOP_V = (RW+1)'(MAX_TOP);
  localparam logic [RW-1:0] WRAP_V    = RW'(MAX_TOP + 1);
  localparam logic [RW:0]   GAP_V     = (RW+1)'(GAP);
  localparam logic [CW-1:0] BASE_LIM  = CW'(SPAWN_INTERVAL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [COLS-1:0]          valid_q, valid_d;
  logic [COLS-1:0][RW-1:0]  top_q, top_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [7:0]               score_q, score_d;
  logic                     spawn_q, spawn_d;
  logic [RW-1:0]            r_low, new_top, ins_top;
  logic [CW-1:0]            spawn_lim;
  logic                     spawn_hit;
  logic                     unused_rnd;

  assign unused_rnd = ^rnd;
  assign r_low      = rnd[RW-1:0];

  // Fold values above MAX_TOP back into range so every gap fits on screen.
  always_comb begin
    if ({1'b0, r_low} <= MAX_TOP_V) new_top = r_low;
    else                            new_top = r_low - WRAP_V;
  end

`ifdef PIPE_SPAWN_JITTER_EN
  logic [1:0] jitter_q, jitter_d;
  assign spawn_lim = BASE_LIM + CW'(jitter_q);
`else
  assign spawn_lim = BASE_LIM;
`endif

  assign spawn_hit = (cnt_q == spawn_lim);
  assign ins_top   = spawn_hit ? new_top : '0;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    top_d   = top_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    spawn_d = 1'b0;
`ifdef PIPE_SPAWN_JITTER_EN
    jitter_d = jitter_q;
`endif
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          valid_d = '0;
          top_d   = '0;
          cnt_d   = '0;
          score_d = '0;
`ifdef PIPE_SPAWN_JITTER_EN
          jitter_d = 2'd0;
`endif
        end
      end
      RUN: begin
        if (halt) begin
          state_d = HALT;
        end else if (tick) begin
          valid_d = {spawn_hit, valid_q[COLS-1:1]};
          top_d   = {ins_top, top_q[COLS-1:1]};
          if (valid_q[BIRD_COL] && (score_q != 8'hFF)) score_d = score_q + 8'd1;
          if (spawn_hit) begin
            cnt_d   = '0;
            spawn_d = 1'b1;
`ifdef PIPE_SPAWN_JITTER_EN
            jitter_d = rnd[5:4];
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= '0;
      top_q   <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      spawn_q <= 1'b0;
`ifdef PIPE_SPAWN_JITTER_EN
      jitter_q <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      spawn_q <= spawn_d;
`ifdef PIPE_SPAWN_JITTER_EN
      jitter_q <= jitter_d;
`endif
    end
  end

  assign running         = (state_q == RUN);
  assign score           = score_q;
  assign spawn           = spawn_q;
  assign pipe_at_bird    = valid_q[BIRD_COL];
  assign gap_top_at_bird = valid_q[BIRD_COL] ? top_q[BIRD_COL] : '0;

  // Compare at RW+1 bits so top+GAP never wraps.
  for (genvar c = 0; c < COLS; c++) begin : g_col
    for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam logic [RW:0] ROW_V = (RW+1)'(r);
      assign pipe_map[c*ROWS+r] = valid_q[c] &&
        ((ROW_V < {1'b0, top_q[c]}) || (ROW_V >= ({1'b0, top_q[c]} + GAP_V)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_field_gen.sv
`default_nettype none
// Testbench for pipe_field_gen: gap-mapping vector table, scrolling/score
// sequences, halt/restart/reset corners and score saturation.
module tb_pipe_field_gen;

  logic         clk = 1'b0;
  logic         reset = 1'b1, start = 1'b0, halt = 1'b0, tick = 1'b0;
  logic [5:0]   rnd = 6'd0;
  logic [255:0] pipe_map;
  logic         pipe_at_bird, spawn, running;
  logic [3:0]   gap_top_at_bird;
  logic [7:0]   score;

  logic         reset2 = 1'b1, start2 = 1'b0, halt2 = 1'b0, tick2 = 1'b0;
  logic [5:0]   rnd2 = 6'd0;
  logic [255:0] pipe_map2;
  logic         pipe_at_bird2, spawn2, running2;
  logic [3:0]   gap_top_at_bird2;
  logic [7:0]   score2;

  always #5 clk = ~clk;

  pipe_field_gen u_dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt), .tick(tick), .rnd(rnd),
    .pipe_map(pipe_map), .pipe_at_bird(pipe_at_bird), .gap_top_at_bird(gap_top_at_bird),
    .score(score), .spawn(spawn), .running(running)
  );

  pipe_field_gen #(.SPAWN_INTERVAL(2)) u_dut2 (
    .clk(clk), .reset(reset2), .start(start2), .halt(halt2), .tick(tick2), .rnd(rnd2),
    .pipe_map(pipe_map2), .pipe_at_bird(pipe_at_bird2), .gap_top_at_bird(gap_top_at_bird2),
    .score(score2), .spawn(spawn2), .running(running2)
  );

  typedef struct {
    logic [255:0] map;
    logic         pab;
    logic [3:0]   gt;
    logic [7:0]   score;
    logic         spawn;
    logic         running;
  } exp_t;

  typedef struct {
    logic [5:0]  rnd;
    logic [3:0]  top;
    logic [15:0] pat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[7];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t exp_idle();
    exp_t x;
    x.map = '0; x.pab = 1'b0; x.gt = 4'd0; x.score = 8'd0; x.spawn = 1'b0; x.running = 1'b0;
    return x;
  endfunction

  // Interval-6 field after k ticks since start, every pipe spawned with top/pat.
  function automatic exp_t exp_run(input int k, input logic [15:0] pat, input logic [3:0] top);
    exp_t x;
    x = exp_idle();
    x.running = 1'b1;
    x.spawn = (k > 0) && (k % 6 == 0);
    for (int n = 6; n <= k; n += 6) begin
      int col;
      col = 15 - (k - n);
      if (col >= 0) x.map[col*16 +: 16] = pat;
      if (col == 3) begin
        x.pab = 1'b1;
        x.gt  = top;
      end
      if (col <= 2) x.score = x.score + 8'd1;
    end
    return x;
  endfunction

  task automatic check_pop();
    exp_t x;
    if (sb.size() == 0) begin
      chk("sb_underflow", 256'(1), 256'(0));
    end else begin
      x = sb.pop_front();
      chk("pipe_map", pipe_map, x.map);
      chk("pipe_at_bird", 256'(pipe_at_bird), 256'(x.pab));
      chk("gap_top_at_bird", 256'(gap_top_at_bird), 256'(x.gt));
      chk("score", 256'(score), 256'(x.score));
      chk("spawn", 256'(spawn), 256'(x.spawn));
      chk("running", 256'(running), 256'(x.running));
    end
  endtask

  // Drive one clock of inputs (from a negedge), then compare at the next negedge.
  task automatic cycle(input logic rs, input logic st, input logic h, input logic t,
                       input logic [5:0] r, input exp_t x);
    reset = rs; start = st; halt = h; tick = t; rnd = r;
    sb.push_back(x);
    @(negedge clk);
    reset = 1'b0; start = 1'b0; halt = 1'b0; tick = 1'b0;
    check_pop();
  endtask

  initial begin
    int exp_sc;
    vecs[0] = '{6'b000101, 4'd5,  16'hFE1F};
    vecs[1] = '{6'b001110, 4'd1,  16'hFFE1};
    vecs[2] = '{6'b001100, 4'd12, 16'h0FFF};
    vecs[3] = '{6'b101101, 4'd0,  16'hFFF0};
    vecs[4] = '{6'b001111, 4'd2,  16'hFFC3};
    vecs[5] = '{6'b111011, 4'd11, 16'h87FF};
    vecs[6] = '{6'b010111, 4'd7,  16'hF87F};

    @(negedge clk);
    cycle(1, 0, 0, 0, 6'd0, exp_idle());
    cycle(1, 0, 0, 0, 6'd0, exp_idle());
    cycle(0, 0, 0, 1, 6'd5, exp_idle());

    // Gap mapping: start (IDLE or HALT), six ticks, then halt.
    for (int i = 0; i < 7; i++) begin
      cycle(0, 1, 0, 0, 6'd0, exp_run(0, vecs[i].pat, vecs[i].top));
      for (int k = 1; k <= 6; k++)
        cycle(0, 0, 0, 1, vecs[i].rnd, exp_run(k, vecs[i].pat, vecs[i].top));
      e = exp_run(6, vecs[i].pat, vecs[i].top);
      e.running = 1'b0; e.spawn = 1'b0;
      cycle(0, 0, 1, 0, 6'd0, e);
    end

    // Pipe travels to the bird column, then scores.
    cycle(0, 1, 0, 0, 6'd0, exp_run(0, 16'hFE1F, 4'd5));
    for (int k = 1; k <= 19; k++)
      cycle(0, 0, 0, 1, 6'd5, exp_run(k, 16'hFE1F, 4'd5));

    // halt with tick: frozen field; later ticks and halt release stay frozen.
    e = exp_run(19, 16'hFE1F, 4'd5);
    e.running = 1'b0; e.spawn = 1'b0;
    cycle(0, 0, 1, 1, 6'd5, e);
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 6'd5, e);
    cycle(0, 0, 1, 1, 6'd5, e);

    // start+halt in HALT restarts; held halt then stops the new game.
    cycle(0, 1, 1, 0, 6'd0, exp_run(0, 16'hFE1F, 4'd5));
    e = exp_idle();
    cycle(0, 0, 1, 0, 6'd0, e);
    cycle(0, 0, 0, 1, 6'd5, e);

    // Reset mid-game with score 3.
    cycle(0, 1, 0, 0, 6'd0, exp_run(0, 16'hFE1F, 4'd5));
    for (int k = 1; k <= 31; k++)
      cycle(0, 0, 0, 1, 6'd5, exp_run(k, 16'hFE1F, 4'd5));
    cycle(1, 1, 1, 1, 6'd5, exp_idle());
    for (int k = 0; k < 3; k++) cycle(0, 0, 0, 1, 6'd5, exp_idle());
    cycle(0, 1, 0, 0, 6'd0, exp_run(0, 16'hFE1F, 4'd5));
    for (int k = 1; k <= 6; k++)
      cycle(0, 0, 0, 1, 6'd5, exp_run(k, 16'hFE1F, 4'd5));
    cycle(1, 1, 0, 0, 6'd0, exp_idle());
    chk("sb_empty", 256'(sb.size()), 256'(0));

    // Score saturation on a SPAWN_INTERVAL=2 instance, ticking every cycle.
    reset2 = 1'b0; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("dut2_running", 256'(running2), 256'(1));
    chk("dut2_score0", 256'(score2), 256'(0));
    tick2 = 1'b1;
    for (int k = 1; k <= 640; k++) begin
      rnd2 = 6'($urandom_range(0, 63));
      @(negedge clk);
      exp_sc = (k >= 13) ? (k - 13) / 2 : 0;
      if (exp_sc > 255) exp_sc = 255;
      chk("dut2_score", 256'(score2), 256'(exp_sc));
    end
    tick2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
